// File: rtl/risc_control_unit_if.sv
// risc_control_unit_if: IR/flag inputs and datapath strobes between control unit and datapath
interface risc_control_unit_if #(
   parameter int word_size = 10,
   parameter int Sel1_size = 3,
   parameter int Sel2_size = 3
);
   logic [word_size-1:0] instruction;
   logic                 Zflag;
   logic                 Load_R0, Load_R1, Load_R2, Load_R3;
   logic                 Load_PC, Inc_PC;
   logic [Sel1_size-1:0] Sel_Bus_1a_Mux, Sel_Bus_1b_Mux;
   logic [Sel2_size-1:0] Sel_Bus_2_Mux;
   logic                 Load_IR, Load_Add_R, Load_Reg_Z;
   logic                 write, halted;
   modport master (
      output instruction, Zflag,
      input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
             Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux,
             Load_IR, Load_Add_R, Load_Reg_Z, write, halted
   );
   modport slave (
      input  instruction, Zflag,
      output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
             Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux,
             Load_IR, Load_Add_R, Load_Reg_Z, write, halted
   );
endinterface

// File: rtl/risc_control_unit.sv
// risc_control_unit: multi-cycle fetch/decode/execute control FSM for the 10-bit RISC datapath
module risc_control_unit #(
   parameter int word_size  = 10,
   parameter int op_size    = 4,
   parameter int Sel1_size  = 3,
   parameter int Sel2_size  = 3,
   parameter int state_size = 3
) (
   input logic clk,
   input logic rst,
   risc_control_unit_if.slave bus
);
   localparam logic [state_size-1:0] S_idle = 3'd0, S_fet1 = 3'd1, S_fet2 = 3'd2, S_dec = 3'd3,
                                     S_rd = 3'd4, S_wr = 3'd5, S_halt = 3'd6;
   localparam logic [op_size-1:0] NOP = 4'b0000, ADD = 4'b0001, SUB = 4'b0010, AND = 4'b0011,
                                  NOT = 4'b0100, RD = 4'b0101, WR = 4'b0110, BR = 4'b0111,
                                  BRZ = 4'b1000, LDI = 4'b1001, HLT = 4'b1111;

   logic [state_size-1:0] r_state, w_next;
   logic [op_size-1:0]    w_op;
   logic [1:0]            w_src, w_dest;
   logic                  w_ld, w_unused;

   assign w_op     = bus.instruction[word_size-1 -: op_size];
   assign w_src    = bus.instruction[5:4];
   assign w_dest   = bus.instruction[3:2];
   assign w_unused = &{1'b0, bus.instruction[1:0], NOP};

   always_ff @(posedge clk)
      r_state <= rst ? S_idle : w_next;

   always_comb begin
      w_next = S_idle;
      case (r_state)
         S_idle:  w_next = S_fet1;
         S_fet1:  w_next = S_fet2;
         S_fet2:  w_next = S_dec;
         S_dec:   w_next = w_op == RD ? S_rd : w_op == WR ? S_wr : w_op == HLT ? S_halt : S_fet1;
         S_rd:    w_next = S_fet1;
         S_wr:    w_next = S_fet1;
         S_halt:  w_next = S_halt;
         default: w_next = S_idle;
      endcase
   end

   // rst gates every strobe so an aborted instruction cannot commit on the reset edge
   always_comb begin
      w_ld               = 1'b0;
      bus.Load_PC        = 1'b0;
      bus.Inc_PC         = 1'b0;
      bus.Sel_Bus_1a_Mux = '0;
      bus.Sel_Bus_1b_Mux = '0;
      bus.Sel_Bus_2_Mux  = '0;
      bus.Load_IR        = 1'b0;
      bus.Load_Add_R     = 1'b0;
      bus.Load_Reg_Z     = 1'b0;
      bus.write          = 1'b0;
      bus.halted         = 1'b0;
      if (!rst) begin
         case (r_state)
            S_fet1: begin
               bus.Sel_Bus_1a_Mux = Sel1_size'(4);
               bus.Sel_Bus_2_Mux  = Sel2_size'(1);
               bus.Load_Add_R     = 1'b1;
            end
            S_fet2: begin
               bus.Sel_Bus_2_Mux = Sel2_size'(2);
               bus.Load_IR       = 1'b1;
               bus.Inc_PC        = 1'b1;
            end
            S_dec: begin
               case (w_op)
                  ADD, SUB, AND, NOT: begin
                     bus.Sel_Bus_1a_Mux = Sel1_size'(w_src);
                     bus.Sel_Bus_1b_Mux = Sel1_size'(w_dest);
                     w_ld               = 1'b1;
                     bus.Load_Reg_Z     = 1'b1;
                  end
                  RD, WR: begin
                     bus.Sel_Bus_2_Mux = Sel2_size'(3);
                     bus.Load_Add_R    = 1'b1;
                  end
                  BR: begin
                     bus.Sel_Bus_2_Mux = Sel2_size'(3);
                     bus.Load_PC       = 1'b1;
                  end
                  BRZ: begin
                     bus.Sel_Bus_2_Mux = bus.Zflag ? Sel2_size'(3) : '0;
                     bus.Load_PC       = bus.Zflag;
                  end
                  LDI: begin
                     bus.Sel_Bus_2_Mux = Sel2_size'(4);
                     w_ld              = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_rd: begin
               bus.Sel_Bus_2_Mux = Sel2_size'(2);
               w_ld              = 1'b1;
            end
            S_wr: begin
               bus.Sel_Bus_1a_Mux = Sel1_size'(w_src);
               bus.write          = 1'b1;
            end
            S_halt: bus.halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.Load_R0 = w_ld && w_dest == 2'd0;
   assign bus.Load_R1 = w_ld && w_dest == 2'd1;
   assign bus.Load_R2 = w_ld && w_dest == 2'd2;
   assign bus.Load_R3 = w_ld && w_dest == 2'd3;
endmodule

// File: tb/tb_risc_control_unit.sv
// tb_risc_control_unit: directed per-scenario checks of the control unit strobe sequences
module tb_risc_control_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   risc_control_unit_if bus ();
   risc_control_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   // packed order: R3 R2 R1 R0 | PC Inc | 1a | 1b | 2 | IR AddR Z write halted
   function automatic logic [19:0] mk(input logic [3:0] r, input logic pc, input logic inc,
                                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] s2,
                                      input logic ir, input logic ar, input logic z,
                                      input logic w, input logic h);
      return {r, pc, inc, a, b, s2, ir, ar, z, w, h};
   endfunction

   function automatic logic [19:0] obs();
      return {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0, bus.Load_PC, bus.Inc_PC,
              bus.Sel_Bus_1a_Mux, bus.Sel_Bus_1b_Mux, bus.Sel_Bus_2_Mux,
              bus.Load_IR, bus.Load_Add_R, bus.Load_Reg_Z, bus.write, bus.halted};
   endfunction

   logic [19:0] ZERO, FET1, FET2, ADDR, HALT;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [19:0] exp_v [4];
      exp_v = '{ZERO, ZERO, ZERO, FET1};
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 2) rst = 1'b0;
         n_cmp++;
         if (obs() !== exp_v[i]) begin
            n_fail++;
            $display("FAIL reset[%0d] got %h want %h", i, obs(), exp_v[i]);
         end
      end
   endtask

   task automatic test_add;
      logic [19:0] exp_v [4];
      exp_v = '{FET1, FET2, mk(4'b0100, 0, 0, 3'd1, 3'd2, 3'd0, 0, 0, 1, 0, 0), FET1};
      bus.instruction = 10'b0001_01_10_00;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (obs() !== exp_v[i]) begin
            n_fail++;
            $display("FAIL add[%0d] got %h want %h", i, obs(), exp_v[i]);
         end
         if (i < 3) step();
      end
   endtask

   task automatic test_alu_misc;
      logic [9:0]  ins [8];
      logic [19:0] dec [8];
      ins = '{10'b0000_00_00_00, 10'b0010_11_00_00, 10'b0011_00_11_00, 10'b0100_10_01_00,
              10'b0111_00_00_00, 10'b1001_00_01_00, 10'b1010_11_11_11, 10'b1110_01_10_11};
      dec = '{ZERO,
              mk(4'b0001, 0, 0, 3'd3, 3'd0, 3'd0, 0, 0, 1, 0, 0),
              mk(4'b1000, 0, 0, 3'd0, 3'd3, 3'd0, 0, 0, 1, 0, 0),
              mk(4'b0010, 0, 0, 3'd2, 3'd1, 3'd0, 0, 0, 1, 0, 0),
              mk(4'b0000, 1, 0, 3'd0, 3'd0, 3'd3, 0, 0, 0, 0, 0),
              mk(4'b0010, 0, 0, 3'd0, 3'd0, 3'd4, 0, 0, 0, 0, 0),
              ZERO, ZERO};
      for (int k = 0; k < 8; k++) begin
         bus.instruction = ins[k];
         step();
         step();
         n_cmp++;
         if (obs() !== dec[k]) begin
            n_fail++;
            $display("FAIL dec_%b got %h want %h", ins[k], obs(), dec[k]);
         end
         step();
         n_cmp++;
         if (obs() !== FET1) begin
            n_fail++;
            $display("FAIL after_%b got %h want %h", ins[k], obs(), FET1);
         end
      end
   endtask

   task automatic test_rd_wr;
      logic [19:0] exp_v [5];
      exp_v = '{FET1, FET2, ADDR, mk(4'b1000, 0, 0, 3'd0, 3'd0, 3'd2, 0, 0, 0, 0, 0), FET1};
      bus.instruction = 10'b0101_00_11_00;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (obs() !== exp_v[i]) begin
            n_fail++;
            $display("FAIL rd[%0d] got %h want %h", i, obs(), exp_v[i]);
         end
         if (i < 4) step();
      end
      exp_v = '{FET1, FET2, ADDR, mk(4'b0000, 0, 0, 3'd1, 3'd0, 3'd0, 0, 0, 0, 1, 0), FET1};
      bus.instruction = 10'b0110_01_00_00;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (obs() !== exp_v[i]) begin
            n_fail++;
            $display("FAIL wr[%0d] got %h want %h", i, obs(), exp_v[i]);
         end
         if (i < 4) step();
      end
   endtask

   task automatic test_brz;
      logic [19:0] dec [2];
      dec = '{mk(4'b0000, 1, 0, 3'd0, 3'd0, 3'd3, 0, 0, 0, 0, 0), ZERO};
      bus.instruction = 10'b1000_00_00_00;
      for (int k = 0; k < 2; k++) begin
         bus.Zflag = (k == 0);
         step();
         step();
         n_cmp++;
         if (obs() !== dec[k]) begin
            n_fail++;
            $display("FAIL brz_z%0d got %h want %h", bus.Zflag, obs(), dec[k]);
         end
         step();
      end
      bus.Zflag = 1'b0;
   endtask

   task automatic test_halt;
      bus.instruction = 10'b1111_00_00_00;
      step();
      step();
      n_cmp++;
      if (obs() !== ZERO) begin
         n_fail++;
         $display("FAIL hlt_dec got %h want %h", obs(), ZERO);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         n_cmp++;
         if (obs() !== HALT) begin
            n_fail++;
            $display("FAIL halted[%0d] got %h want %h", i, obs(), HALT);
         end
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== ZERO) begin
         n_fail++;
         $display("FAIL hlt_rst got %h want %h", obs(), ZERO);
      end
      step();
      rst = 1'b0;
      n_cmp++;
      if (obs() !== ZERO) begin
         n_fail++;
         $display("FAIL hlt_idle got %h want %h", obs(), ZERO);
      end
      step();
      n_cmp++;
      if (obs() !== FET1) begin
         n_fail++;
         $display("FAIL hlt_fet1 got %h want %h", obs(), FET1);
      end
   endtask

   task automatic test_reset_mid_rd;
      bus.instruction = 10'b0101_00_11_00;
      step();
      step();
      step();
      n_cmp++;
      if (obs() !== mk(4'b1000, 0, 0, 3'd0, 3'd0, 3'd2, 0, 0, 0, 0, 0)) begin
         n_fail++;
         $display("FAIL mid_rd_state got %h want %h", obs(), mk(4'b1000, 0, 0, 3'd0, 3'd0, 3'd2, 0, 0, 0, 0, 0));
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.Load_R3 !== 1'b0 || obs() !== ZERO) begin
         n_fail++;
         $display("FAIL mid_rd_abort got %h want %h", obs(), ZERO);
      end
      step();
      rst = 1'b0;
      n_cmp++;
      if (obs() !== ZERO) begin
         n_fail++;
         $display("FAIL mid_rd_idle got %h want %h", obs(), ZERO);
      end
      step();
      n_cmp++;
      if (obs() !== FET1) begin
         n_fail++;
         $display("FAIL mid_rd_fet1 got %h want %h", obs(), FET1);
      end
   endtask

   initial begin
      ZERO = '0;
      FET1 = mk(4'b0000, 0, 0, 3'd4, 3'd0, 3'd1, 0, 1, 0, 0, 0);
      FET2 = mk(4'b0000, 0, 1, 3'd0, 3'd0, 3'd2, 1, 0, 0, 0, 0);
      ADDR = mk(4'b0000, 0, 0, 3'd0, 3'd0, 3'd3, 0, 1, 0, 0, 0);
      HALT = mk(4'b0000, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 1);
      bus.instruction = '0;
      bus.Zflag = 1'b0;
      test_reset();
      test_add();
      test_alu_misc();
      test_rd_wr();
      test_brz();
      test_halt();
      test_reset_mid_rd();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/risc_control_unit.md
Name: risc_control_unit

Overview:
- Control FSM for the 10-bit RISC MCU datapath.
- Consumes the instruction register contents and the Z flag from the processing unit.
- Generates every register-load, PC, bus-select and memory-write strobe that drives that datapath.
- Implements a multi-cycle fetch/decode/execute sequence, one instruction at a time.

Parameters:
- word_size, 10, instruction width; opcode = instruction[9:6], src = [5:4], dest = [3:2], [1:0] ignored.
- op_size, 4, opcode width.
- Sel1_size, 3, Bus_1a/Bus_1b select width.
- Sel2_size, 3, Bus_2 select width.
- state_size, 3, state register width.

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- instruction  input  word_size  current IR contents.
- Zflag  input  1  registered ALU zero flag.
- Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  register load strobes.
- Load_PC  output  1  PC load from Bus_2.
- Inc_PC  output  1  PC increment.
- Sel_Bus_1a_Mux  output  Sel1_size  0..3=R0..R3, 4=PC.
- Sel_Bus_1b_Mux  output  Sel1_size  0..3=R0..R3, 4=PC.
- Sel_Bus_2_Mux  output  Sel2_size  0=alu_out, 1=Bus_1a, 2=mem_word, 3=address_decoded, 4=constant_decoded.
- Load_IR, Load_Add_R, Load_Reg_Z  output  1 each  IR, address register, Z register loads.
- write  output  1  memory write enable; address = address register, data = Bus_1a.
- halted  output  1  high while in S_halt.

Behaviour:
- All outputs are combinational from (state, instruction, Zflag).
- Outputs are 0 in S_idle, and while rst=1 regardless of state.
- Only one Load_Rn is ever high, selected by dest.
- Reset: the rising edge with rst=1 sets state to S_idle. rst mid-instruction aborts it; no strobe fires on that edge.

States:
- S_idle: no outputs. Next state is S_fet1.
- S_fet1: Sel_Bus_1a=4, Sel_Bus_2=1, Load_Add_R=1. Next state is S_fet2.
- S_fet2: Sel_Bus_2=2, Load_IR=1, Inc_PC=1. Next state is S_dec.
- S_dec: decodes the opcode:
  - NOP 0000: no strobe; next state S_fet1.
  - ADD 0001, SUB 0010, AND 0011, NOT 0100: Sel_Bus_1a=src, Sel_Bus_1b=dest, Sel_Bus_2=0, Load_R[dest]=1, Load_Reg_Z=1; next state S_fet1.
  - RD 0101: Sel_Bus_2=3, Load_Add_R=1; next state S_rd.
  - WR 0110: Sel_Bus_2=3, Load_Add_R=1; next state S_wr.
  - BR 0111: Sel_Bus_2=3, Load_PC=1; next state S_fet1.
  - BRZ 1000: if Zflag=1, Sel_Bus_2=3 and Load_PC=1, else no strobe; next state S_fet1. Zflag is sampled in S_dec.
  - LDI 1001: Sel_Bus_2=4, Load_R[dest]=1; next state S_fet1.
  - HLT 1111: no strobe; next state S_halt.
  - 1010 to 1110: treated as NOP.
- S_rd: Sel_Bus_2=2, Load_R[dest]=1. Next state is S_fet1.
- S_wr: Sel_Bus_1a=src, write=1. Next state is S_fet1.
- S_halt: halted=1, no strobes. The only exit is rst.

Timing:
- ALU/NOP/BR/BRZ/LDI instructions take 3 cycles.
- RD and WR take 4 cycles.
- Load_PC and Inc_PC are never high together.
- Unused select values default to 0.

Test Plan:
- Reset: rst=1 for 2 cycles, then release. Required: all strobes 0 while rst=1. First post-reset cycle is S_idle, then S_fet1 with Load_Add_R=1, Sel_Bus_1a=4, Sel_Bus_2=1.
- Fetch plus ADD: instruction=10'b0001_01_10_00 in S_dec. Required: Sel_Bus_1a=1, Sel_Bus_1b=2, Sel_Bus_2=0, Load_R2=1, Load_Reg_Z=1, and the next cycle is S_fet1. One full instruction spans exactly 3 cycles.
- RD then WR: RD with dest=3 gives Load_Add_R with Sel_Bus_2=3, then Load_R3 with Sel_Bus_2=2. WR with src=1 gives Load_Add_R, then write=1 with Sel_Bus_1a=1. Each takes 4 cycles and no other Load_Rn is asserted.
- BRZ: with Zflag=1, Load_PC=1 and Sel_Bus_2=3 in S_dec. With Zflag=0, there is no Load_PC and Inc_PC stays 0 in S_dec.
- HLT then recovery: opcode 1111 gives halted=1 from the next cycle, all strobes 0 for 10+ cycles. Then rst=1 for one cycle returns to S_idle with halted=0.
- Reset mid-RD: rst asserted in S_rd. Required: no Load_R3 at that edge, and the next state is S_idle.
